// File: rtl/fft3_frame_ctrl.sv
// Frame sequencer for the radix-3 multi-size FFT: latches the stage code, streams
// 3^k samples into the FFT, counts output strobes and reports done or timeout.
module fft3_frame_ctrl #(
  parameter int WIDTH      = 18,
  parameter int CFG_CYCLES = 2,
  parameter int TIMEOUT    = 1023
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       size_sel,
  output logic             busy,
  output logic             err,
  output logic             done,
  input  logic             src_valid,
  output logic             src_ready,
  input  logic [WIDTH-1:0] src_re,
  input  logic [WIDTH-1:0] src_im,
  output logic [2:0]       fft_stages,
  output logic             fft_di_en,
  output logic [WIDTH-1:0] fft_di_re,
  output logic [WIDTH-1:0] fft_di_im,
  input  logic             fft_do_en,
  output logic [2:0]       state_dbg
);

  // Handshake: a sample moves on every rising edge where src_valid and src_ready
  // are both high; src_ready depends only on the state register, never on src_valid.

  localparam int CW = (CFG_CYCLES > 1) ? $clog2(CFG_CYCLES) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CFG   = 3'd1,
    S_LOAD  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] cfg_cnt;
  logic [TW-1:0] wd_cnt;
  logic [7:0]    in_cnt;
  logic [7:0]    out_cnt;
  logic [7:0]    n_len;
  logic          size_ok;
  logic          last_in;
  logic [8:0]    out_total;
  logic          drain_done;
  logic          drain_timeout;

  function automatic logic [7:0] frame_len(input logic [2:0] code);
    case (code)
      3'd1:    return 8'd3;
      3'd2:    return 8'd9;
      3'd3:    return 8'd27;
      3'd4:    return 8'd81;
      3'd5:    return 8'd243;
      default: return 8'd0;
    endcase
  endfunction

  assign busy      = (state != S_IDLE);
  assign src_ready = (state == S_LOAD);
  assign state_dbg = state;

  always_comb begin
    state_next    = state;
    size_ok       = (size_sel >= 3'd1) && (size_sel <= 3'd5);
    last_in       = src_valid && (in_cnt == n_len - 8'd1);
    out_total     = {1'b0, out_cnt} + {8'd0, fft_do_en};
    drain_done    = (out_total >= {1'b0, n_len});
    // Timeout fires on the TIMEOUT-th consecutive drain cycle without a strobe.
    drain_timeout = !fft_do_en && (wd_cnt == TW'(TIMEOUT - 1));
    case (state)
      S_IDLE:  if (start && size_ok) state_next = S_CFG;
      S_CFG:   if (cfg_cnt == CW'(CFG_CYCLES - 1)) state_next = S_LOAD;
      S_LOAD:  if (last_in) state_next = S_DRAIN;
      S_DRAIN: begin
        if (drain_done)         state_next = S_DONE;
        else if (drain_timeout) state_next = S_IDLE;
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err        <= 1'b0;
      done       <= 1'b0;
      fft_stages <= 3'd0;
      fft_di_en  <= 1'b0;
      fft_di_re  <= '0;
      fft_di_im  <= '0;
      cfg_cnt    <= '0;
      wd_cnt     <= '0;
      in_cnt     <= 8'd0;
      out_cnt    <= 8'd0;
      n_len      <= 8'd0;
    end else begin
      err       <= 1'b0;
      done      <= 1'b0;
      fft_di_en <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (size_ok) begin
              fft_stages <= size_sel;
              n_len      <= frame_len(size_sel);
              cfg_cnt    <= '0;
              wd_cnt     <= '0;
              in_cnt     <= 8'd0;
              out_cnt    <= 8'd0;
            end else begin
              err <= 1'b1;
            end
          end
        end
        S_CFG: cfg_cnt <= cfg_cnt + 1'b1;
        S_LOAD: begin
          if (src_valid) begin
            fft_di_en <= 1'b1;
            fft_di_re <= src_re;
            fft_di_im <= src_im;
            in_cnt    <= in_cnt + 8'd1;
          end
          if (fft_do_en) out_cnt <= out_cnt + 8'd1;
          wd_cnt <= '0;
        end
        S_DRAIN: begin
          if (fft_do_en) begin
            out_cnt <= out_cnt + 8'd1;
            wd_cnt  <= '0;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
          if (drain_done)         done <= 1'b1;
          else if (drain_timeout) err  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
